// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: memory read port plus the decode valid/ready handshake.
interface instr_fetch_if #(
    parameter int unsigned WORD_WIDTH = 16
);
    logic [WORD_WIDTH-1:0] mem_address;
    logic                  mem_wr_en;
    logic [WORD_WIDTH-1:0] mem_data_out;
    logic                  instr_valid;
    logic                  instr_ready;
    logic [WORD_WIDTH-1:0] instr_data;
    logic [WORD_WIDTH-1:0] instr_pc;

    modport master (
        output mem_address, mem_wr_en, instr_valid, instr_data, instr_pc,
        input  mem_data_out, instr_ready
    );

    modport slave (
        input  mem_address, mem_wr_en, instr_valid, instr_data, instr_pc,
        output mem_data_out, instr_ready
    );
endinterface

// File: rtl/instr_fetch.sv
// Sequential instruction fetch: issues 1-cycle mem reads, buffers words for decode.
// Define FETCH_BOUNDS_CHECK_EN to fault on out-of-range PCs instead of wrapping.
module instr_fetch #(
    parameter int unsigned MEM_DEPTH  = 1024,
    parameter int unsigned WORD_WIDTH = 16,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  redirect_valid,
    input  logic [WORD_WIDTH-1:0] redirect_addr,
    instr_fetch_if.master         bus,
    output logic                  fetch_fault
);
    localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CW = $clog2(BUF_DEPTH) + 1;

    typedef logic [PW-1:0]         ptr_t;
    typedef logic [CW-1:0]         cnt_t;
    typedef logic [CW:0]           occ_t;
    typedef logic [WORD_WIDTH-1:0] word_t;

    localparam word_t LAST_PC   = word_t'(MEM_DEPTH - 2);
    localparam word_t EVEN_MASK = ~word_t'(1);

`ifdef FETCH_BOUNDS_CHECK_EN
    typedef enum logic [1:0] {IDLE, RUN, FAULT} state_t;
`else
    typedef enum logic [1:0] {IDLE, RUN} state_t;
`endif

    state_t state_q, state_d;
    word_t  pc_q, last_addr_q, inflight_pc_q;
    logic   inflight_q;
    word_t  data_mem [BUF_DEPTH];
    word_t  pc_mem   [BUF_DEPTH];
    ptr_t   head_q, tail_q;
    cnt_t   count_q;

    logic   buf_valid, pop, push, issue;
    word_t  pc_seq, redir_pc;
    occ_t   occ;
`ifdef FETCH_BOUNDS_CHECK_EN
    logic   fault_set;
`endif

    // Issue only while buffer slots not yet claimed by held or in-flight words remain.
    always_comb begin
        buf_valid = (count_q != '0);
        pop       = buf_valid & bus.instr_ready;
        push      = inflight_q & ~redirect_valid;
        occ       = occ_t'(count_q) + occ_t'(inflight_q) - occ_t'(pop);
        issue     = (state_q == RUN) && enable && !redirect_valid &&
                    (occ < occ_t'(BUF_DEPTH));
        pc_seq    = (pc_q == LAST_PC) ? '0 : pc_q + word_t'(2);
`ifdef FETCH_BOUNDS_CHECK_EN
        redir_pc  = redirect_addr & EVEN_MASK;
        fault_set = (redirect_valid && (redirect_addr >= word_t'(MEM_DEPTH - 1))) ||
                    (issue && (pc_q == LAST_PC));
`else
        redir_pc  = word_t'(32'(redirect_addr & EVEN_MASK) % MEM_DEPTH);
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable && !redirect_valid) state_d = RUN;
            RUN:     if (!enable) state_d = IDLE;
            default: state_d = state_q;
        endcase
`ifdef FETCH_BOUNDS_CHECK_EN
        if (fault_set) state_d = FAULT;
`endif
    end

    always_comb begin
        bus.mem_address = issue ? pc_q : last_addr_q;
        bus.mem_wr_en   = 1'b0;
        bus.instr_valid = buf_valid;
        bus.instr_data  = buf_valid ? data_mem[head_q] : '0;
        bus.instr_pc    = buf_valid ? pc_mem[head_q]   : '0;
`ifdef FETCH_BOUNDS_CHECK_EN
        fetch_fault     = (state_q == FAULT);
`else
        fetch_fault     = 1'b0;
`endif
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q          <= '0;
            last_addr_q   <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
        end else begin
            if (redirect_valid) pc_q <= redir_pc;
            else if (issue)     pc_q <= pc_seq;
            if (issue) begin
                last_addr_q   <= pc_q;
                inflight_pc_q <= pc_q;
            end
            inflight_q <= issue;
            if (redirect_valid) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (push) tail_q <= tail_q + ptr_t'(1);
                if (pop)  head_q <= head_q + ptr_t'(1);
                count_q <= count_q + cnt_t'(push) - cnt_t'(pop);
            end
        end
    end

    // Storage needs no reset: count_q gates every read of it.
    always_ff @(posedge clock) begin
        if (push) begin
            data_mem[tail_q] <= bus.mem_data_out;
            pc_mem[tail_q]   <= inflight_pc_q;
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: stream-order model checked each cycle plus directed literal checks.
module tb_instr_fetch;
    localparam int unsigned MEM_DEPTH  = 1024;
    localparam int unsigned WORD_WIDTH = 16;
    localparam int unsigned BUF_DEPTH  = 2;

    logic clock = 1'b0;
    logic reset, enable, redirect_valid, fetch_fault;
    logic [WORD_WIDTH-1:0] redirect_addr;
    int compared = 0;
    int mismatched = 0;

    instr_fetch_if #(.WORD_WIDTH(WORD_WIDTH)) bus ();

    instr_fetch #(
        .MEM_DEPTH(MEM_DEPTH),
        .WORD_WIDTH(WORD_WIDTH),
        .BUF_DEPTH(BUF_DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .enable(enable),
        .redirect_valid(redirect_valid),
        .redirect_addr(redirect_addr),
        .bus(bus),
        .fetch_fault(fetch_fault)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] word_of(input logic [15:0] a);
        return a ^ 16'hC3A5;
    endfunction

    // Memory: word at the requested address appears one cycle later.
    initial bus.mem_data_out = '0;
    always @(posedge clock) bus.mem_data_out <= word_of(bus.mem_address);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic int unsigned next_pc(input int unsigned p);
        return (p + 2) % MEM_DEPTH;
    endfunction

    function automatic int unsigned target_pc(input int unsigned a);
`ifdef FETCH_BOUNDS_CHECK_EN
        return (a / 2) * 2;
`else
        return ((a / 2) * 2) % MEM_DEPTH;
`endif
    endfunction

    // Model: delivered pcs form a contiguous +2 stream restarted by reset/redirect.
    logic        seen_rst = 1'b0, after_rst = 1'b0, after_flush = 1'b0, hold_prev = 1'b0;
    int unsigned exp_pc = 0;
    logic [15:0] held_pc = '0, held_data = '0;

    always @(negedge clock) begin
        if (seen_rst) begin
            check("wr_en_zero", 32'(bus.mem_wr_en), 32'd0);
            check("addr_even", 32'(bus.mem_address[0]), 32'd0);
            check("addr_range", 32'(bus.mem_address < 16'(MEM_DEPTH)), 32'd1);
            if (after_flush) check("valid_after_flush", 32'(bus.instr_valid), 32'd0);
            if (after_rst) begin
                check("rst_addr", 32'(bus.mem_address), 32'd0);
                check("rst_pc", 32'(bus.instr_pc), 32'd0);
                check("rst_data", 32'(bus.instr_data), 32'd0);
                check("rst_fault", 32'(fetch_fault), 32'd0);
            end
            if (hold_prev) begin
                check("hold_valid", 32'(bus.instr_valid), 32'd1);
                check("hold_pc", 32'(bus.instr_pc), 32'(held_pc));
                check("hold_data", 32'(bus.instr_data), 32'(held_data));
            end
            if (bus.instr_valid === 1'b1) begin
                check("stream_pc", 32'(bus.instr_pc), exp_pc);
                check("stream_data", 32'(bus.instr_data), 32'(word_of(16'(exp_pc))));
            end
        end
        if (reset) begin
            seen_rst    <= 1'b1;
            after_rst   <= 1'b1;
            after_flush <= 1'b1;
            hold_prev   <= 1'b0;
            exp_pc      <= 0;
        end else begin
            after_rst   <= 1'b0;
            after_flush <= redirect_valid;
            hold_prev   <= !redirect_valid && (bus.instr_valid === 1'b1) && !bus.instr_ready;
            held_pc     <= bus.instr_pc;
            held_data   <= bus.instr_data;
            if (redirect_valid) exp_pc <= target_pc(32'(redirect_addr));
            else if (bus.instr_valid === 1'b1 && bus.instr_ready) exp_pc <= next_pc(exp_pc);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; redirect_valid = 1'b0; redirect_addr = '0;
        bus.instr_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1; reset = 1'b0; enable = 1'b1; #1;
        check("c0_valid", 32'(bus.instr_valid), 32'd0);
        check("c0_addr", 32'(bus.mem_address), 32'd0);
        check("c0_fault", 32'(fetch_fault), 32'd0);

        // Streaming from reset: first word two cycles after first issue.
        for (int k = 0; k < 6; k++) begin
            tick(); #1;
            check("t1_addr", 32'(bus.mem_address), 32'(2 * k));
            check("t1_valid", 32'(bus.instr_valid), 32'(k >= 2));
            if (k >= 2) check("t1_pc", 32'(bus.instr_pc), 32'(2 * (k - 2)));
        end
        check("t1_data", 32'(bus.instr_data), 32'hC3A3);

        // Decode stall: two words held, issue stops, then resumes in order.
        tick(); bus.instr_ready = 1'b0; #1;
        check("t2_addr", 32'(bus.mem_address), 32'd10);
        check("t2_pc", 32'(bus.instr_pc), 32'd8);
        repeat (4) tick();
        #1;
        check("t2_hold_valid", 32'(bus.instr_valid), 32'd1);
        check("t2_hold_pc", 32'(bus.instr_pc), 32'd8);
        check("t2_hold_addr", 32'(bus.mem_address), 32'd10);
        tick(); bus.instr_ready = 1'b1; #1;
        check("t2_rel_pc", 32'(bus.instr_pc), 32'd8);
        check("t2_rel_addr", 32'(bus.mem_address), 32'd12);
        tick(); #1;
        check("t2_pc10", 32'(bus.instr_pc), 32'd10);
        tick(); #1;
        check("t2_pc12", 32'(bus.instr_pc), 32'd12);

        // Redirect to odd address with word buffered and read in flight.
        tick(); bus.instr_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 16'h0101; #1;
        check("t3_addr_held", 32'(bus.mem_address), 32'd16);
        tick(); redirect_valid = 1'b0; bus.instr_ready = 1'b1; #1;
        check("t3_valid0", 32'(bus.instr_valid), 32'd0);
        check("t3_addr", 32'(bus.mem_address), 32'h100);
        tick(); #1;
        check("t3_valid1", 32'(bus.instr_valid), 32'd0);
        check("t3_addr2", 32'(bus.mem_address), 32'h102);
        tick(); #1;
        check("t3_first_valid", 32'(bus.instr_valid), 32'd1);
        check("t3_first_pc", 32'(bus.instr_pc), 32'h100);
        check("t3_first_data", 32'(bus.instr_data), 32'hC2A5);

        // Reset mid-stream: stale in-flight data must not surface.
        tick(); reset = 1'b1; #1;
        tick(); reset = 1'b0; enable = 1'b0; #1;
        check("t5_valid", 32'(bus.instr_valid), 32'd0);
        check("t5_pc", 32'(bus.instr_pc), 32'd0);
        check("t5_data", 32'(bus.instr_data), 32'd0);
        check("t5_addr", 32'(bus.mem_address), 32'd0);
        check("t5_fault", 32'(fetch_fault), 32'd0);
        tick(); enable = 1'b1; #1;
        check("t5_no_stale", 32'(bus.instr_valid), 32'd0);
        check("t5_idle_addr", 32'(bus.mem_address), 32'd0);

        // Enable drop: in-flight word still delivered, then buffer drains.
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            check("t6_addr", 32'(bus.mem_address), 32'(2 * k));
            check("t6_valid", 32'(bus.instr_valid), 32'(k >= 2));
        end
        tick(); enable = 1'b0; #1;
        check("t6_drop_addr", 32'(bus.mem_address), 32'd6);
        check("t6_drop_pc", 32'(bus.instr_pc), 32'd4);
        tick(); #1;
        check("t6_last_valid", 32'(bus.instr_valid), 32'd1);
        check("t6_last_pc", 32'(bus.instr_pc), 32'd6);
        tick(); #1;
        check("t6_drained", 32'(bus.instr_valid), 32'd0);

        // Redirect in IDLE to the top of memory, then run across the end.
        tick(); redirect_valid = 1'b1; redirect_addr = 16'h03FC; #1;
        check("t4_idle_valid", 32'(bus.instr_valid), 32'd0);
        tick(); redirect_valid = 1'b0; enable = 1'b1; #1;
        check("t4_idle_addr", 32'(bus.mem_address), 32'd6);
        tick(); #1;
        check("t4_addr_3fc", 32'(bus.mem_address), 32'h3FC);
        tick(); #1;
        check("t4_addr_3fe", 32'(bus.mem_address), 32'h3FE);
        tick(); #1;
        check("t4_pc_3fc", 32'(bus.instr_pc), 32'h3FC);
`ifdef FETCH_BOUNDS_CHECK_EN
        check("t4_fault", 32'(fetch_fault), 32'd1);
        check("t4_addr_stop", 32'(bus.mem_address), 32'h3FE);
        tick(); #1;
        check("t4_pc_3fe", 32'(bus.instr_pc), 32'h3FE);
        check("t4_addr_stop2", 32'(bus.mem_address), 32'h3FE);
        tick(); #1;
        check("t4_no_more", 32'(bus.instr_valid), 32'd0);
        check("t4_fault_sticky", 32'(fetch_fault), 32'd1);
        repeat (4) tick();
        #1;
        check("t4_fault_end", 32'(fetch_fault), 32'd1);
        check("t4_end_valid", 32'(bus.instr_valid), 32'd0);
        check("t4_end_addr", 32'(bus.mem_address), 32'h3FE);
`else
        check("t4_fault", 32'(fetch_fault), 32'd0);
        check("t4_addr_wrap", 32'(bus.mem_address), 32'd0);
        tick(); #1;
        check("t4_pc_3fe", 32'(bus.instr_pc), 32'h3FE);
        check("t4_addr_2", 32'(bus.mem_address), 32'd2);
        tick(); #1;
        check("t4_wrap_valid", 32'(bus.instr_valid), 32'd1);
        check("t4_wrap_pc", 32'(bus.instr_pc), 32'd0);
        // Redirect beyond MEM_DEPTH lands modulo memory size.
        tick(); bus.instr_ready = 1'b0; redirect_valid = 1'b1; redirect_addr = 16'h0403; #1;
        tick(); redirect_valid = 1'b0; bus.instr_ready = 1'b1; #1;
        check("t4_mod_valid", 32'(bus.instr_valid), 32'd0);
        check("t4_mod_addr", 32'(bus.mem_address), 32'd2);
        tick(); #1;
        check("t4_mod_addr2", 32'(bus.mem_address), 32'd4);
        tick(); #1;
        check("t4_mod_pc", 32'(bus.instr_pc), 32'd2);
`endif
        repeat (3) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
